// File: rtl/mf_slicer_pkg.sv
// ---------------------------------------------------------------------------
// mf_slicer_pkg
// Shared constants and types for the one-bit parallel datapath. The table /
// mapper side uses the same amplitude and sample width, so both ends agree
// on what a "+DATA" sample looks like.
//   SAMPLE_W   : signed sample width coming out of the filter/table
//   DATA_AMP   : magnitude of one enabled data bit
//   accWidth() : integrator width that can hold SPS worst-case samples
// ---------------------------------------------------------------------------
package mf_slicer_pkg;

    localparam int SAMPLE_W = 17;
    localparam int DATA_AMP = 100;

    // Hard decision polarity: a positive sum means data bit 0.
    typedef enum logic {
        BIT_POS = 1'b0,
        BIT_NEG = 1'b1
    } sliceBit_e;

    // One symbol decision as handed from the integrator to the packer.
    typedef struct packed {
        logic      strobe;
        sliceBit_e dataBit;
        logic      zero;
    } decision_t;

    // Sum of sps signed width-bit samples fits in width + clog2(sps) bits.
    function automatic int accWidth(input int width, input int sps);
        return width + $clog2(sps);
    endfunction

endpackage

// File: rtl/mf_slicer_if.sv
// ---------------------------------------------------------------------------
// mf_slicer_if
// Sample input and packed-word output of the slicer in one bundle.
//   in_valid / in_sample / sync : sample stream from the filter side
//   out_valid / out_ready       : word handshake to the consumer
//   out_data / out_zero         : packed word and its erasure flag
//   overrun                     : sticky "a completed word was dropped"
// The slave modport is the slicer; the master modport is whoever feeds
// samples and consumes words.
// ---------------------------------------------------------------------------
interface mf_slicer_if
    import mf_slicer_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int WORD  = 8
) ();

    logic                    in_valid;
    logic signed [WIDTH-1:0] in_sample;
    logic                    sync;
    logic                    out_valid;
    logic                    out_ready;
    logic [WORD-1:0]         out_data;
    logic                    out_zero;
    logic                    overrun;

    modport slave (
        input  in_valid, in_sample, sync, out_ready,
        output out_valid, out_data, out_zero, overrun
    );

    modport master (
        output in_valid, in_sample, sync, out_ready,
        input  out_valid, out_data, out_zero, overrun
    );

endinterface

// File: rtl/mf_integrate_dump.sv
// ---------------------------------------------------------------------------
// mf_integrate_dump
// Integrate-and-dump over SPS valid samples with a hard sign/zero decision.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_valid     : sample qualifier; idle cycles change nothing
//   i_sample    : signed sample
//   i_sync      : with i_valid, this sample starts a new symbol
//   o_decision  : combinational decision strobe on the last sample of a
//                 symbol (bit = sign of the sum, zero = sum was exactly 0)
// ---------------------------------------------------------------------------
module mf_integrate_dump
    import mf_slicer_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int SPS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_sample,
    input  logic                    i_sync,
    output decision_t               o_decision
);

    localparam int ACC_W = accWidth(WIDTH, SPS);
    localparam int PH_W  = $clog2(SPS);

    logic signed [ACC_W-1:0] r_acc;
    logic [PH_W-1:0]         r_phase;
    logic signed [ACC_W-1:0] w_sampleExt;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_lastSample;

    assign w_sampleExt  = {{(ACC_W-WIDTH){i_sample[WIDTH-1]}}, i_sample};
    assign w_sum        = r_acc + w_sampleExt;
    assign w_lastSample = i_valid && (r_phase == PH_W'(SPS - 1));

    // The decision is taken from the full symbol sum including the current
    // sample, so the packer can register the bit on the same edge. A sync
    // landing on the last phase restarts the symbol instead of deciding.
    always_comb begin
        o_decision         = '0;
        o_decision.strobe  = w_lastSample && !i_sync;
        o_decision.dataBit = w_sum[ACC_W-1] ? BIT_NEG : BIT_POS;
        o_decision.zero    = w_lastSample && !i_sync && (w_sum == '0);
    end

    // Accumulator and phase only move on valid samples. Sync seeds the
    // accumulator with the current sample as phase 0, so the next phase is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (i_valid) begin
            if (i_sync) begin
                r_acc   <= w_sampleExt;
                r_phase <= PH_W'(1);
            end else if (w_lastSample) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mf_slicer.sv
// ---------------------------------------------------------------------------
// mf_slicer
// Receive-side decision block: integrates samples per symbol, slices to a
// hard bit, packs WORD bits LSB-first and offers words over valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mf_slicer_if slave (sample input, word output, overrun)
// ---------------------------------------------------------------------------
module mf_slicer
    import mf_slicer_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int SPS   = 4,
    parameter int WORD  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mf_slicer_if.slave  bus
);

    localparam int BC_W = $clog2(WORD);

    decision_t        w_dec;
    logic [WORD-1:0]  r_shift;
    logic [BC_W-1:0]  r_bitCnt;
    logic             r_zeroAcc;
    logic             r_outValid;
    logic [WORD-1:0]  r_outData;
    logic             r_outZero;
    logic             r_overrun;
    logic             w_resync;
    logic             w_wordDone;
    logic [WORD-1:0]  w_word;
    logic             w_wordZero;
    logic             w_outFree;

    mf_integrate_dump #(
        .WIDTH (WIDTH),
        .SPS   (SPS)
    ) u_intDump (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (bus.in_valid),
        .i_sample   (bus.in_sample),
        .i_sync     (bus.sync),
        .o_decision (w_dec)
    );

    // New bits enter at the top and shift down, so after WORD decisions the
    // first-decided bit sits in bit 0.
    assign w_resync   = bus.in_valid && bus.sync;
    assign w_wordDone = w_dec.strobe && (r_bitCnt == BC_W'(WORD - 1));
    assign w_word     = {w_dec.dataBit, r_shift[WORD-1:1]};
    assign w_wordZero = r_zeroAcc || w_dec.zero;
    assign w_outFree  = !r_outValid || bus.out_ready;

    // Packer: collects decisions into a word and a word-local zero flag.
    // Sync throws away the partial word; a finished word always restarts
    // the packer whether or not the output register could take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_zeroAcc <= 1'b0;
        end else if (w_resync || w_wordDone) begin
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_zeroAcc <= 1'b0;
        end else if (w_dec.strobe) begin
            r_shift   <= w_word;
            r_bitCnt  <= r_bitCnt + 1'b1;
            r_zeroAcc <= w_wordZero;
        end
    end

    // Output register: a finished word loads if the slot is empty or being
    // drained on this same edge; otherwise the held word wins and the new
    // one is dropped with a sticky overrun that only reset clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outZero  <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_wordDone) begin
            if (w_outFree) begin
                r_outValid <= 1'b1;
                r_outData  <= w_word;
                r_outZero  <= w_wordZero;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_zero  = r_outZero;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_mf_slicer.sv
// ---------------------------------------------------------------------------
// tb_mf_slicer
// Directed bench for mf_slicer with WIDTH=17, SPS=4, WORD=8, DATA=100.
// ---------------------------------------------------------------------------
module tb_mf_slicer;
    import mf_slicer_pkg::*;

    localparam logic signed [SAMPLE_W-1:0] POS  = SAMPLE_W'(DATA_AMP);
    localparam logic signed [SAMPLE_W-1:0] NEG  = -SAMPLE_W'(DATA_AMP);
    localparam logic signed [SAMPLE_W-1:0] POS2 = SAMPLE_W'(2 * DATA_AMP);
    localparam logic signed [SAMPLE_W-1:0] NEG2 = -SAMPLE_W'(2 * DATA_AMP);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] wordD = 8'hC3;
    logic [7:0] wordE = 8'h81;

    mf_slicer_if #(.WIDTH(SAMPLE_W), .WORD(8)) ifc ();

    mf_slicer #(
        .WIDTH (SAMPLE_W),
        .SPS   (4),
        .WORD  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Present one input cycle; returns 1 ns after the edge that captured it.
    task automatic applyStimulus(input logic v, input logic signed [SAMPLE_W-1:0] s,
                                 input logic sy);
        ifc.in_valid  = v;
        ifc.in_sample = s;
        ifc.sync      = sy;
        @(posedge clk);
        #1;
        ifc.in_valid  = 1'b0;
        ifc.sync      = 1'b0;
    endtask

    // Four samples of one data bit: bit 0 is +DATA, bit 1 is -DATA.
    task automatic sendSymbol(input logic b, input logic syncFirst);
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, b ? NEG : POS, syncFirst && (k == 0));
    endtask

    task automatic sendWord(input logic [7:0] bits, input logic syncFirst);
        for (int i = 0; i < 8; i++)
            sendSymbol(bits[i], syncFirst && (i == 0));
    endtask

    // Compare outputs; data/zero are only compared when checkData is set.
    task automatic checkOutput(input string tag, input logic expValid,
                               input logic [7:0] expData, input logic expZero,
                               input logic expOvr, input logic checkData);
        checks++;
        assert (ifc.out_valid === expValid) else begin
            failures++;
            $error("[TB] FAIL %s out_valid: got %b expected %b", tag, ifc.out_valid, expValid);
        end
        checks++;
        assert (ifc.overrun === expOvr) else begin
            failures++;
            $error("[TB] FAIL %s overrun: got %b expected %b", tag, ifc.overrun, expOvr);
        end
        if (checkData) begin
            checks++;
            assert (ifc.out_data === expData) else begin
                failures++;
                $error("[TB] FAIL %s out_data: got %h expected %h", tag, ifc.out_data, expData);
            end
            checks++;
            assert (ifc.out_zero === expZero) else begin
                failures++;
                $error("[TB] FAIL %s out_zero: got %b expected %b", tag, ifc.out_zero, expZero);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_sample = '0;
        ifc.sync      = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // All-zero bits: valid rises only on the 32nd sample.
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b1, POS, n == 0);
            checkOutput("t1_sample", n == 31, 8'h00, 1'b0, 1'b0, n == 31);
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t1_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Alternating bits: +200 symbols decide 0, -100 symbols decide 1.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++)
                applyStimulus(1'b1, (i % 2 == 1) ? NEG : POS2, 1'b0);
        checkOutput("t2_alt", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t2_alt_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Zero-sum symbol in bit 3 decides 0 and flags the word.
        for (int i = 0; i < 3; i++) sendSymbol(1'b0, 1'b0);
        applyStimulus(1'b1, POS, 1'b0);
        applyStimulus(1'b1, NEG, 1'b0);
        applyStimulus(1'b1, POS2, 1'b0);
        applyStimulus(1'b1, NEG2, 1'b0);
        for (int i = 4; i < 8; i++) sendSymbol(1'b1, 1'b0);
        checkOutput("t2_zero", 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t2_zero_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Same-cycle accept and load keeps out_valid high without overrun.
        ifc.out_ready = 1'b0;
        sendWord(8'h55, 1'b0);
        checkOutput("t4_first", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) sendSymbol(wordD[i], 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, wordD[7] ? NEG : POS, 1'b0);
        checkOutput("t4_hold", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        ifc.out_ready = 1'b1;
        applyStimulus(1'b1, wordD[7] ? NEG : POS, 1'b0);
        checkOutput("t4_b2b", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Backpressure: first word held, second dropped, overrun sticks.
        ifc.out_ready = 1'b0;
        sendWord(8'h0F, 1'b0);
        checkOutput("t3_first", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sendSymbol(i >= 4, 1'b0);
            checkOutput("t3_stable", 1'b1, 8'h0F, 1'b0, i == 7, 1'b1);
        end
        ifc.out_ready = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t3_accept", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t3_sticky", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Mid-word resync at sample 13, gaps carry an unqualified sync.
        for (int n = 0; n < 12; n++) applyStimulus(1'b1, NEG, 1'b0);
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b1, wordE[n / 4] ? NEG : POS, n == 0);
            checkOutput("t5_sample", n == 31, 8'h81, 1'b0, 1'b1, n == 31);
            if (n % 3 == 1) applyStimulus(1'b0, SAMPLE_W'(5000), 1'b1);
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t5_drop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-word while a word is held.
        ifc.out_ready = 1'b0;
        sendWord(8'h00, 1'b0);
        for (int n = 0; n < 5; n++) applyStimulus(1'b1, POS, 1'b0);
        checkOutput("t6_before", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        for (int n = 0; n < 32; n++) applyStimulus(1'b1, NEG, 1'b0);
        checkOutput("t6_ones", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t6_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mf_slicer.md
# mf_slicer

Receive-side decision block for the one-bit parallel datapath. It consumes the signed matched-filter/table samples (data bit 0 maps to +DATA, data bit 1 maps to −DATA, two enabled bits sum to ±2·DATA) and integrates them over a symbol period with integrate-and-dump. It slices the sum to a hard bit and packs bits LSB-first into words. Packed words go to a downstream consumer over a valid/ready handshake, together with a zero-sum (erasure) flag and a sticky overrun flag.

## Interface
Parameters:
- WIDTH, 17, input sample width (signed, matches table output width)
- SPS, 4, valid samples per symbol (≥2)
- WORD, 8, bits per output word (≥2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_sample is valid this cycle
- in_sample  input  WIDTH  signed filter/table sample
- sync  input  1  symbol/word alignment, qualified by in_valid
- out_valid  output  1  out_data/out_zero hold a word
- out_ready  input  1  consumer accepts word when out_valid & out_ready
- out_data  output  WORD  packed bits, first-decided bit in bit 0
- out_zero  output  1  at least one bit in this word was decided from a sum of exactly 0
- overrun  output  1  sticky; a completed word was dropped

## Operation
- Internal width ACC_W = WIDTH + clog2(SPS). The accumulator is sign-extended and never saturates or wraps.
- Phase counter counts valid samples 0..SPS−1. Cycles without in_valid change nothing.
- Symbol sum S = acc + in_sample on the valid sample at phase SPS−1. On that sample, acc clears to 0. On other valid samples, acc ← S.
- Decision: S > 0 gives bit 0. S < 0 gives bit 1. S == 0 gives bit 0 and sets a word-local zero flag.
- Bits shift into a WORD-bit register, LSB first. The bit counter runs 0..WORD−1.
- Word completion happens when a decision occurs at bit count WORD−1:
  - If the output register is free (out_valid=0), or is being taken in the same cycle (out_valid & out_ready), load it with {word, zero flag}.
  - Otherwise drop the new word, keep the held word unchanged, and set overrun.
  - In all cases, the shift register, bit counter and zero flag restart.
- sync with in_valid: this sample is phase 0 of a new symbol and bit 0 of a new word.
  - acc ← sign-extended in_sample.
  - The partial word and zero flag are discarded.
  - The output register and overrun are unaffected.
  - If SPS samples complete on the same cycle as sync, sync wins and no decision is made.
- sync without in_valid is ignored.
- overrun clears only on reset.

## Timing
- Reset values: out_valid=0, out_data=0, out_zero=0, overrun=0. Accumulator, phase, bit counter and shift register are all 0.
- Latency: out_valid rises on the clock edge that registers the last valid sample of the WORD-th symbol. out_data appears one cycle after that sample is presented.
- Handshake:
  - out_data/out_zero are stable while out_valid=1 and out_ready=0.
  - out_valid falls the cycle after acceptance unless a new word loads on that same edge. In that case out_valid stays high for back-to-back words.
- Throughput: one word per WORD·SPS valid samples. in_valid may be asserted every cycle. There is no input backpressure.
- Reset assertion mid-word or mid-handshake clears everything immediately (asynchronous). Partial data is lost.

## Structure
- Shared package for the one-bit datapath: the DATA amplitude constant, the sample width constant (17), and the clog2-based ACC_W helper, shared with the table/mapper side.
- One natural sub-module: mf_integrate_dump (accumulator + phase counter, emits the sign/zero decision strobe). The top level holds the packer, the output register and overrun.

## Test plan
Use WIDTH=17, SPS=4, WORD=8, DATA=100 unless noted.
1. **All-zero bits.** 32 valid samples of +100 (sync on the first), out_ready=1 → one word 8'h00, out_zero=0, out_valid for exactly 1 cycle.
2. **Alternating bits.** Symbols alternating +200×4 / −100×4 → out_data=8'hAA (bit0=0, bit1=1). Then symbol sums of 0 (+100,−100,+200,−200) in bit 3 → that bit is 0 and out_zero=1.
3. **Backpressure and overrun.** Hold out_ready=0 across two complete words → first word is held stable, second is dropped, overrun=1 and stays set. Then raise out_ready → out_valid drops next cycle.
4. **Same-cycle accept and load.** A word completes on the same cycle as out_valid & out_ready → new word loads, out_valid stays 1, no overrun.
5. **Mid-word resync.** Assert sync at sample 13 → the partial word is discarded. The next word boundary falls at sample 13+32, and in_valid gaps are ignored.
6. **Reset mid-operation.** Async rst_n pulse mid-word with out_valid=1 → all outputs 0 immediately. Then 32 samples of −100 → 8'hFF.
